// File: rtl/jc_pkg.sv
// Shared helpers for the parametrised Johnson counter: phase <-> ring-pattern
// conversion and direction encodings.
package jc_pkg;

  // Upper bound on ring length the helper functions can represent.
  localparam int JC_MAX_W = 64;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ring pattern for a phase index: phases 0..W fill ones in from the MSB,
  // phases W+1..2W-1 drain them out from the MSB again.
  function automatic logic [JC_MAX_W-1:0] jc_pattern(input int phase, input int width);
    logic [JC_MAX_W-1:0] p;
    p = '0;
    for (int i = 0; i < JC_MAX_W; i++) begin
      if (i < width) begin
        if ((phase <= width && i >= width - phase) ||
            (phase >  width && i <  2 * width - phase))
          p = p | (JC_MAX_W'(1) << i);
      end
    end
    return p;
  endfunction

  // Phase index of a ring pattern: the ones count on the filling half,
  // mirrored around 2W on the draining half.
  function automatic int jc_phase(input logic [JC_MAX_W-1:0] q, input int width);
    logic [JC_MAX_W-1:0] t;
    logic                msb;
    int                  pop;
    pop = 0;
    t   = q;
    for (int i = 0; i < JC_MAX_W; i++) begin
      if (i < width) pop += int'(t[0]);
      t = t >> 1;
    end
    t   = q >> (width - 1);
    msb = t[0];
    if (pop == 0 || msb) return pop;
    return 2 * width - pop;
  endfunction

endpackage

// File: rtl/jc_phase_decode.sv
// Combinational decode of a Johnson ring state into its binary phase index,
// plus a flag telling whether the state is one of the 2*WIDTH legal patterns.
module jc_phase_decode
  import jc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             legal
);

  // A state is legal exactly when re-encoding its decoded phase reproduces it.
  always_comb begin
    phase = PW'(jc_phase(JC_MAX_W'(q), WIDTH));
    legal = (q == WIDTH'(jc_pattern(int'(phase), WIDTH)));
  end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson counter with enable, direction, phase load, phase index
// and wrap pulse. Define JC_SELF_CORRECT_EN to add illegal-state recovery.
module johnson_counter_param
  import jc_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [PW-1:0]    load_phase,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap
`ifdef JC_SELF_CORRECT_EN
  ,
  output logic             illegal
`endif
);

  localparam logic [PW-1:0] LAST_PHASE = PW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_next;
  logic [PW-1:0]    cur_phase;
  logic [PW-1:0]    next_phase;
  logic             cur_legal;
  logic             next_legal;
  logic             load_ok;
  logic             stepping;
  logic             wrap_next;

  jc_phase_decode #(.WIDTH(WIDTH), .PW(PW)) u_cur_decode (
    .q     (q),
    .phase (cur_phase),
    .legal (cur_legal)
  );

  jc_phase_decode #(.WIDTH(WIDTH), .PW(PW)) u_next_decode (
    .q     (q_next),
    .phase (next_phase),
    .legal (next_legal)
  );

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    q_step = q;
    case (dir)
      DIR_UP:   q_step = {~q[0], q[WIDTH-1:1]};
      DIR_DOWN: q_step = {q[WIDTH-2:0], ~q[WIDTH-1]};
    endcase

    load_ok  = int'(load_phase) < 2 * WIDTH;
    stepping = 1'b0;
    q_next   = q;
    if (load) begin
      // An out-of-range target suppresses the step as well as the load.
      if (load_ok) q_next = WIDTH'(jc_pattern(int'(load_phase), WIDTH));
    end else if (en) begin
      q_next   = q_step;
      stepping = 1'b1;
    end

    wrap_next = stepping && cur_legal && next_legal &&
                ((dir == DIR_UP) ? (cur_phase == LAST_PHASE && next_phase == '0)
                                 : (cur_phase == '0 && next_phase == LAST_PHASE));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      phase <= '0;
      wrap  <= 1'b0;
    end
`ifdef JC_SELF_CORRECT_EN
    else if (!cur_legal) begin
      q     <= '0;
      phase <= '0;
      wrap  <= 1'b0;
    end
`endif
    else begin
      q     <= q_next;
      phase <= next_phase;
      wrap  <= wrap_next;
    end
  end

`ifdef JC_SELF_CORRECT_EN
  always_ff @(posedge clk) begin
    illegal <= !rst && !cur_legal;
  end
`endif

endmodule

// File: tb/tb_johnson_counter_param.sv
// Self-checking bench: WIDTH=4, 3 and 2 counters share stimulus and are
// compared every cycle against a phase-arithmetic reference model.
module tb_johnson_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, dir, load;
  logic [2:0] lp;

  logic [3:0] q4;  logic [2:0] ph4; logic w4;
  logic [2:0] q3;  logic [2:0] ph3; logic w3;
  logic [1:0] q2;  logic [1:0] ph2; logic w2;
`ifdef JC_SELF_CORRECT_EN
  logic il4, il3, il2;
`endif

  johnson_counter_param #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_phase(lp),
    .q(q4), .phase(ph4), .wrap(w4)
`ifdef JC_SELF_CORRECT_EN
    , .illegal(il4)
`endif
  );

  johnson_counter_param #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_phase(lp),
    .q(q3), .phase(ph3), .wrap(w3)
`ifdef JC_SELF_CORRECT_EN
    , .illegal(il3)
`endif
  );

  johnson_counter_param #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_phase(lp[1:0]),
    .q(q2), .phase(ph2), .wrap(w2)
`ifdef JC_SELF_CORRECT_EN
    , .illegal(il2)
`endif
  );

  int   checks   = 0;
  int   failures = 0;
  int   m_phase[3];
  logic m_wrap[3];
  bit   model_valid = 1'b0;
  bit   cmp_en      = 1'b1;

  function automatic int wid(input int i);
    return 4 - i;
  endfunction

  // Ring pattern from phase: p ones at the top while filling, then 2W-p ones at the bottom.
  function automatic logic [3:0] exp_q(input int w, input int p);
    int v;
    if (p <= w) v = ((1 << p) - 1) << (w - p);
    else        v = (1 << (2 * w - p)) - 1;
    return 4'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a phase counter modulo 2W per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int n;
      int lpi;
      n   = 2 * wid(i);
      lpi = (i == 2) ? int'(lp[1:0]) : int'(lp);
      if (rst) begin
        m_phase[i] = 0;
        m_wrap[i]  = 1'b0;
      end else if (load) begin
        if (lpi < n) m_phase[i] = lpi;
        m_wrap[i] = 1'b0;
      end else if (en) begin
        if (dir) begin
          m_wrap[i]  = (m_phase[i] == n - 1);
          m_phase[i] = (m_phase[i] + 1) % n;
        end else begin
          m_wrap[i]  = (m_phase[i] == 0);
          m_phase[i] = (m_phase[i] + n - 1) % n;
        end
      end else begin
        m_wrap[i] = 1'b0;
      end
    end
    if (rst) model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid && cmp_en) begin
      check("cmp_q4",     q4,  exp_q(4, m_phase[0]));
      check("cmp_phase4", ph4, m_phase[0]);
      check("cmp_wrap4",  w4,  m_wrap[0]);
      check("cmp_q3",     q3,  exp_q(3, m_phase[1]));
      check("cmp_phase3", ph3, m_phase[1]);
      check("cmp_wrap3",  w3,  m_wrap[1]);
      check("cmp_q2",     q2,  exp_q(2, m_phase[2]));
      check("cmp_phase2", ph2, m_phase[2]);
      check("cmp_wrap2",  w2,  m_wrap[2]);
`ifdef JC_SELF_CORRECT_EN
      check("cmp_illegal4", il4, 0);
      check("cmp_illegal3", il3, 0);
      check("cmp_illegal2", il2, 0);
`endif
    end
  end

  task automatic cyc(input logic r, input logic e, input logic d, input logic l,
                     input logic [2:0] p);
    rst = r; en = e; dir = d; load = l; lp = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] up_seq [8];
    logic [3:0] dn_seq [4];
    int         dn_ph  [4];
    logic [1:0] seq2   [4];
    up_seq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    dn_seq = '{4'b1100, 4'b1000, 4'b0000, 4'b0001};
    dn_ph  = '{2, 1, 0, 7};
    seq2   = '{2'b10, 2'b11, 2'b01, 2'b00};

    rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; lp = 3'd0;

    // Reset then a full forward lap.
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    check("reset_q",     q4,  4'b0000);
    check("reset_phase", ph4, 0);
    check("reset_wrap",  w4,  0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 1, 0, 0);
      check("up_q",     q4,  up_seq[k]);
      check("up_phase", ph4, (k + 1) % 8);
      check("up_wrap",  w4,  (k == 7));
    end
    check("model_phase_after_lap", m_phase[0], 0);

    // Climb to phase 3, then reverse through the wrap.
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 0);
    check("pre_down_q", q4, 4'b1110);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0, 0);
      check("down_q",     q4,  dn_seq[k]);
      check("down_phase", ph4, dn_ph[k]);
      check("down_wrap",  w4,  (k == 3));
    end
    check("model_phase_after_down", m_phase[0], 7);

    // Load beats enable; an out-of-range phase is ignored even with en=1.
    cyc(0, 1, 1, 1, 5);
    check("load_q4",     q4,  4'b0111);
    check("load_phase4", ph4, 5);
    check("load_wrap4",  w4,  0);
    check("load_q3",     q3,  3'b001);
    check("load_phase3", ph3, 5);
    cyc(0, 1, 1, 1, 7);
    check("badload_q3",     q3,  3'b001);
    check("badload_phase3", ph3, 5);
    check("badload_wrap3",  w3,  0);
    check("load7_q4",       q4,  4'b0001);

    // Hold with en=0, then reset wins over load and enable.
    cyc(0, 0, 1, 1, 6);
    check("load6_q4", q4, 4'b0011);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, k[0], 0, 3'(k));
      check("hold_q",    q4,  4'b0011);
      check("hold_wrap", w4,  0);
    end
    cyc(1, 1, 1, 1, 3);
    check("rst_prio_q4",     q4,  4'b0000);
    check("rst_prio_phase4", ph4, 0);
    check("rst_prio_q2",     q2,  2'b00);

    // Smallest ring: four states, wrap every fourth step.
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 1, 0, 0);
      check("w2_q",    q2, seq2[k % 4]);
      check("w2_wrap", w2, (k % 4 == 3));
    end

`ifdef JC_SELF_CORRECT_EN
    cmp_en = 1'b0;
    cyc(0, 0, 1, 0, 0);
    @(negedge clk);
    force dut4.q = 4'b0101;
    #1;
    release dut4.q;
    @(posedge clk);
    #1;
    check("sc_q",       q4,  4'b0000);
    check("sc_phase",   ph4, 0);
    check("sc_illegal", il4, 1);
    cyc(0, 1, 1, 0, 0);
    check("sc_resume_q",       q4,  4'b1000);
    check("sc_resume_illegal", il4, 0);
    cyc(1, 0, 1, 0, 0);
    cmp_en = 1'b1;
`endif

    // Randomised traffic; the negedge compare process does the checking.
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
          ($urandom_range(5) == 0), 3'($urandom_range(7)));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
